cursor_ring_ctrl: RTL

//  Sequences the on-screen user interface of the RTC VGA display.
//  - Tracks the edit cursor over the nine numeric fields: date, month, year, clock h/m/s and timer h/m/s.
//  - Generates the frame-synchronised 1 Hz blink phase.
//  - Runs the timer-expiry RING alert.
//  - Drives the dir/cursor/blink/ring inputs of the text generator. Sits between the button front-end and the text generator.

---
 rtl/rtc_ui_pkg.sv | 23 ++
 rtl/blink_divider.sv | 52 +++++
 rtl/cursor_ring_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rtc_ui_pkg.sv
// Shared definitions for the RTC VGA user-interface sequencer: FSM state
// encoding, field codes and the number of editable fields.
package rtc_ui_pkg;

   localparam int unsigned NUM_FIELDS = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EDIT = 2'd1,
      RING = 2'd2
   } ui_state_e;

   localparam logic [3:0] FLD_FECHA  = 4'd0;
   localparam logic [3:0] FLD_MES    = 4'd1;
   localparam logic [3:0] FLD_ANO    = 4'd2;
   localparam logic [3:0] FLD_H_HORA = 4'd3;
   localparam logic [3:0] FLD_H_MIN  = 4'd4;
   localparam logic [3:0] FLD_H_SEG  = 4'd5;
   localparam logic [3:0] FLD_T_HORA = 4'd6;
   localparam logic [3:0] FLD_T_MIN  = 4'd7;
   localparam logic [3:0] FLD_T_SEG  = 4'd8;

endpackage

// File: rtl/blink_divider.sv
// Frame-synchronised blink generator. A free-running counter marks every
// half-period; the toggle is deferred to the next frame start so the text
// never changes phase mid-frame. sec_tick_o pulses with each 0->1 edge.
module blink_divider #(
   parameter int unsigned CLK_HZ = 100000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic frame_start_i,
   output logic blink_o,
   output logic sec_tick_o
);

   localparam int unsigned HALF = CLK_HZ / 2;
   localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] CntMax = CW'(HALF - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d;
   logic          blink_q, blink_d;
   logic          tick_q, tick_d;
   logic          wrap, toggle;

   // Next-state: wrap arms pend; a frame start consumes it (extra wraps are absorbed)
   always_comb begin
      wrap    = (cnt_q == CntMax);
      cnt_d   = wrap ? '0 : cnt_q + 1'b1;
      toggle  = (pend_q | wrap) & frame_start_i;
      pend_d  = toggle ? 1'b0 : (pend_q | wrap);
      blink_d = blink_q ^ toggle;
      tick_d  = toggle & ~blink_q;
   end

   // Divider state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         blink_q <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         blink_q <= blink_d;
         tick_q  <= tick_d;
      end
   end

   assign blink_o    = blink_q;
   assign sec_tick_o = tick_q;

endmodule

// File: rtl/cursor_ring_ctrl.sv
// RTC VGA user-interface sequencer: edit cursor over the numeric fields,
// frame-synchronised blink phase and the timer-expiry RING alert.
// Optional macro RING_ACK_EN: when defined, btn_exit_i silences an active RING.
module cursor_ring_ctrl #(
   parameter int unsigned CLK_HZ     = 100000000,
   parameter int unsigned NUM_FIELDS = 9,
   parameter int unsigned RING_SECS  = 10
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       btn_edit_i,
   input  logic       btn_left_i,
   input  logic       btn_right_i,
   input  logic       btn_exit_i,
   input  logic       t_zero_i,
   input  logic       frame_start_i,
   output logic [3:0] dir_o,
   output logic       cursor_o,
   output logic       blink_o,
   output logic       ring_o
);

   import rtc_ui_pkg::*;

   localparam int unsigned RCW = $clog2(RING_SECS + 1);
   localparam logic [RCW-1:0] RingLast = RCW'(RING_SECS - 1);
   localparam logic [3:0]     LastFld  = 4'(NUM_FIELDS - 1);

   ui_state_e      state_q;
   logic [3:0]     dir_q;
   logic           cursor_q;
   logic           ring_q;
   logic [RCW-1:0] ring_cnt_q;
   logic           armed_q;

   logic sec_tick;
   logic expire;
   logic enter_ring;
   logic ring_ack;
   logic ring_done;

   blink_divider #(
      .CLK_HZ (CLK_HZ)
   ) u_blink_divider (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .frame_start_i (frame_start_i),
      .blink_o       (blink_o),
      .sec_tick_o    (sec_tick)
   );

`ifdef RING_ACK_EN
   assign ring_ack = btn_exit_i;
`else
   assign ring_ack = 1'b0;
`endif

   // Expiry needs a non-zero timer seen first, so a zero timer at power-up stays silent
   assign expire     = t_zero_i & armed_q;
   assign enter_ring = expire & (state_q != RING);
   assign ring_done  = sec_tick & (ring_cnt_q == RingLast);

   // Arm on any non-zero timer value; disarm when the alert starts
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         armed_q <= 1'b0;
      end else if (enter_ring) begin
         armed_q <= 1'b0;
      end else if (!t_zero_i) begin
         armed_q <= 1'b1;
      end
   end

   // UI state machine with registered cursor/ring/dir outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         dir_q      <= FLD_FECHA;
         cursor_q   <= 1'b0;
         ring_q     <= 1'b0;
         ring_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (expire) begin
                  state_q    <= RING;
                  ring_q     <= 1'b1;
                  ring_cnt_q <= '0;
               end else if (btn_edit_i) begin
                  state_q  <= EDIT;
                  cursor_q <= 1'b1;
                  dir_q    <= FLD_FECHA;
               end
            end
            EDIT: begin
               // Expiry wins over any button pressed in the same cycle
               if (expire) begin
                  state_q    <= RING;
                  cursor_q   <= 1'b0;
                  ring_q     <= 1'b1;
                  ring_cnt_q <= '0;
               end else if (btn_exit_i) begin
                  state_q  <= IDLE;
                  cursor_q <= 1'b0;
               end else if (btn_right_i && !btn_left_i) begin
                  dir_q <= (dir_q == LastFld) ? FLD_FECHA : dir_q + 4'd1;
               end else if (btn_left_i && !btn_right_i) begin
                  dir_q <= (dir_q == FLD_FECHA) ? LastFld : dir_q - 4'd1;
               end
            end
            RING: begin
               // A reloaded timer ends the alert at once
               if (!t_zero_i || ring_ack || ring_done) begin
                  state_q <= IDLE;
                  ring_q  <= 1'b0;
               end else if (sec_tick) begin
                  ring_cnt_q <= ring_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q  <= IDLE;
               cursor_q <= 1'b0;
               ring_q   <= 1'b0;
            end
         endcase
      end
   end

   assign dir_o    = dir_q;
   assign cursor_o = cursor_q;
   assign ring_o   = ring_q;

endmodule
